// File: rtl/display_mux.sv
// display_mux: time-multiplexed driver for a 4-digit common-anode
// 7-segment display. Latches four BCD digits on a load strobe, then scans
// them one at a time. Each digit slot opens with one blanked cycle that
// prevents ghosting between digits. Segment and anode drives are active-low.
//
// Optional feature: define SUPRIME_ZEROS_EN to enable leading-zero
// suppression. Digits above the units digit are blanked while they and
// every higher digit are zero. Anode scanning is not affected.
module display_mux #(
    parameter int CICLOS_POR_DIGITO = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carrega,
    input  logic [3:0] digito1,
    input  logic [3:0] digito2,
    input  logic [3:0] digito3,
    input  logic [3:0] digito4,
    output logic [6:0] segmentos,
    output logic [3:0] anodos,
    output logic [1:0] indice
);

    localparam int            CW      = $clog2(CICLOS_POR_DIGITO);
    localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_POR_DIGITO - 1);

    // Active-low {g,f,e,d,c,b,a}. Codes 10..15 show a lone dash on g.
    function automatic logic [6:0] decode_bcd(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    logic [3:0]    lat_r [4];
    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [6:0]    seg_r;
    logic [3:0]    an_r;

    logic          terminal_s;
    logic [CW-1:0] cnt_next_s;
    logic [1:0]    idx_next_s;
    logic [3:0]    cur_digit_s;
    logic          suppress_s;
    logic [6:0]    seg_next_s;
    logic [3:0]    an_next_s;

    // Next refresh-counter and scan-index values.
    always_comb begin
        terminal_s = 1'b0;
        cnt_next_s = cnt_r;
        idx_next_s = idx_r;
        if (cnt_r == CNT_MAX) begin
            terminal_s = 1'b1;
            cnt_next_s = {CW{1'b0}};
            idx_next_s = idx_r + 2'd1;
        end else begin
            terminal_s = 1'b0;
            cnt_next_s = cnt_r + CW'(1);
            idx_next_s = idx_r;
        end
    end

    // Blanking decision for the digit currently selected by the scan index.
    always_comb begin
        suppress_s = 1'b0;
`ifdef SUPRIME_ZEROS_EN
        case (idx_r)
            2'd0:    suppress_s = 1'b0;
            2'd1:    suppress_s = (lat_r[1] == 4'd0) && (lat_r[2] == 4'd0) && (lat_r[3] == 4'd0);
            2'd2:    suppress_s = (lat_r[2] == 4'd0) && (lat_r[3] == 4'd0);
            2'd3:    suppress_s = (lat_r[3] == 4'd0);
            default: suppress_s = 1'b0;
        endcase
`else
        suppress_s = 1'b0;
`endif
    end

    // Segment and anode values for the next output register update.
    always_comb begin
        cur_digit_s = lat_r[idx_r];
        seg_next_s  = 7'b1111111;
        an_next_s   = 4'b1111;
        if (suppress_s) begin
            seg_next_s = 7'b1111111;
        end else begin
            seg_next_s = decode_bcd(cur_digit_s);
        end
        if (cnt_r == {CW{1'b0}}) begin
            an_next_s = 4'b1111;
        end else begin
            an_next_s = ~(4'b0001 << idx_r);
        end
    end

    // Digit latches: reload on the strobe, otherwise hold. Reset wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                lat_r[i] <= 4'd0;
            end
        end else if (carrega) begin
            lat_r[0] <= digito1;
            lat_r[1] <= digito2;
            lat_r[2] <= digito3;
            lat_r[3] <= digito4;
        end else begin
            for (int i = 0; i < 4; i++) begin
                lat_r[i] <= lat_r[i];
            end
        end
    end

    // Refresh counter and scan index, advancing the slot at terminal count.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r <= {CW{1'b0}};
            idx_r <= 2'd0;
        end else begin
            cnt_r <= cnt_next_s;
            idx_r <= idx_next_s;
        end
    end

    // Output register, one cycle behind the counter and scan index.
    always_ff @(posedge clock) begin
        if (reset) begin
            seg_r <= 7'b1111111;
            an_r  <= 4'b1111;
        end else begin
            seg_r <= seg_next_s;
            an_r  <= an_next_s;
        end
    end

    assign segmentos = seg_r;
    assign anodos    = an_r;
    assign indice    = idx_r;

endmodule

// File: tb/tb_display_mux.sv
// Table-driven bench for display_mux with CICLOS_POR_DIGITO = 4.
// Each row gives the inputs for one clock edge and the outputs expected
// just after that edge. Rows follow one continuous run. Expectations for
// leading zeros depend on whether SUPRIME_ZEROS_EN is defined.
module tb_display_mux;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S6    = 7'b0000010;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] S8    = 7'b0000000;
    localparam logic [6:0] SDASH = 7'b0111111;
    localparam logic [6:0] SOFF  = 7'b1111111;
`ifdef SUPRIME_ZEROS_EN
    localparam logic [6:0] ZS    = SOFF;
`else
    localparam logic [6:0] ZS    = S0;
`endif

    logic       clock;
    logic       reset;
    logic       carrega;
    logic [3:0] digito1;
    logic [3:0] digito2;
    logic [3:0] digito3;
    logic [3:0] digito4;
    logic [6:0] segmentos;
    logic [3:0] anodos;
    logic [1:0] indice;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [3:0] d3;
        logic [3:0] d4;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic [1:0] exp_idx;
    } vec_t;

    vec_t vecs[$];

    display_mux #(.CICLOS_POR_DIGITO(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .carrega   (carrega),
        .digito1   (digito1),
        .digito2   (digito2),
        .digito3   (digito3),
        .digito4   (digito4),
        .segmentos (segmentos),
        .anodos    (anodos),
        .indice    (indice)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic rst, input logic ld,
                                input logic [3:0] d1, input logic [3:0] d2,
                                input logic [3:0] d3, input logic [3:0] d4,
                                input logic [3:0] an, input logic [6:0] seg,
                                input logic [1:0] idx);
        vec_t v;
        v.rst = rst; v.ld = ld;
        v.d1 = d1; v.d2 = d2; v.d3 = d3; v.d4 = d4;
        v.exp_an = an; v.exp_seg = seg; v.exp_idx = idx;
        return v;
    endfunction

    // Plain run row: no reset, no load, digit inputs driven to 9 so that
    // any spurious latch update would show up.
    function automatic vec_t run(input logic [3:0] an, input logic [6:0] seg,
                                 input logic [1:0] idx);
        return mk(1'b0, 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, an, seg, idx);
    endfunction

    task automatic check(input int row, input string what,
                         input logic [6:0] got, input logic [6:0] want);
        checks_total++;
        if (got === want) begin
            checks_passed++;
        end else begin
            $display("FAIL row %0d %s: got %b, expected %b", row, what, got, want);
        end
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset   = 1'b1;
        carrega = 1'b0;
        digito1 = 4'd0; digito2 = 4'd0; digito3 = 4'd0; digito4 = 4'd0;

        // Reset with load and 9s pending: latches must stay 0.
        vecs.push_back(mk(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'b1111, SOFF, 2'd0));
        vecs.push_back(mk(1'b1, 1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 4'b1111, SOFF, 2'd0));
        vecs.push_back(run(4'b1111, S0, 2'd0));
        vecs.push_back(run(4'b1110, S0, 2'd0));
        // Load 1,2,3,4 at cnt=2 of slot 0.
        vecs.push_back(mk(1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 4'b1110, S0, 2'd0));
        vecs.push_back(run(4'b1110, S1, 2'd1));
        // One full frame of 16 cycles starting at slot 1.
        vecs.push_back(run(4'b1111, S2, 2'd1));
        vecs.push_back(run(4'b1101, S2, 2'd1));
        vecs.push_back(run(4'b1101, S2, 2'd1));
        vecs.push_back(run(4'b1101, S2, 2'd2));
        vecs.push_back(run(4'b1111, S3, 2'd2));
        vecs.push_back(run(4'b1011, S3, 2'd2));
        vecs.push_back(run(4'b1011, S3, 2'd2));
        vecs.push_back(run(4'b1011, S3, 2'd3));
        vecs.push_back(run(4'b1111, S4, 2'd3));
        vecs.push_back(run(4'b0111, S4, 2'd3));
        vecs.push_back(run(4'b0111, S4, 2'd3));
        vecs.push_back(run(4'b0111, S4, 2'd0));
        vecs.push_back(run(4'b1111, S1, 2'd0));
        vecs.push_back(run(4'b1110, S1, 2'd0));
        vecs.push_back(run(4'b1110, S1, 2'd0));
        vecs.push_back(run(4'b1110, S1, 2'd1));
        // Invalid BCD in the hundreds digit.
        vecs.push_back(mk(1'b0, 1'b1, 4'd1, 4'd2, 4'd12, 4'd4, 4'b1111, S2, 2'd1));
        vecs.push_back(run(4'b1101, S2, 2'd1));
        vecs.push_back(run(4'b1101, S2, 2'd1));
        vecs.push_back(run(4'b1101, S2, 2'd2));
        vecs.push_back(run(4'b1111, SDASH, 2'd2));
        vecs.push_back(run(4'b1011, SDASH, 2'd2));
        // Reset, then load 0,0,0,0 and scan a full frame.
        vecs.push_back(mk(1'b1, 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 4'b1111, SOFF, 2'd0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 4'b1111, S0, 2'd0));
        vecs.push_back(run(4'b1110, S0, 2'd0));
        vecs.push_back(run(4'b1110, S0, 2'd0));
        vecs.push_back(run(4'b1110, S0, 2'd1));
        vecs.push_back(run(4'b1111, ZS, 2'd1));
        vecs.push_back(run(4'b1101, ZS, 2'd1));
        vecs.push_back(run(4'b1101, ZS, 2'd1));
        vecs.push_back(run(4'b1101, ZS, 2'd2));
        vecs.push_back(run(4'b1111, ZS, 2'd2));
        vecs.push_back(run(4'b1011, ZS, 2'd2));
        vecs.push_back(run(4'b1011, ZS, 2'd2));
        vecs.push_back(run(4'b1011, ZS, 2'd3));
        vecs.push_back(run(4'b1111, ZS, 2'd3));
        vecs.push_back(run(4'b0111, ZS, 2'd3));
        vecs.push_back(run(4'b0111, ZS, 2'd3));
        vecs.push_back(run(4'b0111, ZS, 2'd0));
        // Load 5,0,0,0 on the slot-0 guard cycle.
        vecs.push_back(mk(1'b0, 1'b1, 4'd5, 4'd0, 4'd0, 4'd0, 4'b1111, S0, 2'd0));
        vecs.push_back(run(4'b1110, S5, 2'd0));
        vecs.push_back(run(4'b1110, S5, 2'd0));
        vecs.push_back(run(4'b1110, S5, 2'd1));
        vecs.push_back(run(4'b1111, ZS, 2'd1));
        vecs.push_back(run(4'b1101, ZS, 2'd1));
        // Load 0,0,7,0 mid slot 1: tens digit stops being a leading zero.
        vecs.push_back(mk(1'b0, 1'b1, 4'd0, 4'd0, 4'd7, 4'd0, 4'b1101, ZS, 2'd1));
        vecs.push_back(run(4'b1101, S0, 2'd2));
        vecs.push_back(run(4'b1111, S7, 2'd2));
        vecs.push_back(run(4'b1011, S7, 2'd2));
        vecs.push_back(run(4'b1011, S7, 2'd2));
        vecs.push_back(run(4'b1011, S7, 2'd3));
        vecs.push_back(run(4'b1111, ZS, 2'd3));
        vecs.push_back(run(4'b0111, ZS, 2'd3));
        vecs.push_back(run(4'b0111, ZS, 2'd3));
        vecs.push_back(run(4'b0111, ZS, 2'd0));
        vecs.push_back(run(4'b1111, S0, 2'd0));
        vecs.push_back(run(4'b1110, S0, 2'd0));
        vecs.push_back(run(4'b1110, S0, 2'd0));
        vecs.push_back(run(4'b1110, S0, 2'd1));
        vecs.push_back(run(4'b1111, S0, 2'd1));
        vecs.push_back(run(4'b1101, S0, 2'd1));
        vecs.push_back(run(4'b1101, S0, 2'd1));
        vecs.push_back(run(4'b1101, S0, 2'd2));
        vecs.push_back(run(4'b1111, S7, 2'd2));
        // Reset mid-frame at indice=2, cnt=1.
        vecs.push_back(mk(1'b1, 1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 4'b1111, SOFF, 2'd0));
        // Reload mid-slot: units digit 3, then 8 at cnt=2 of slot 0.
        vecs.push_back(mk(1'b0, 1'b1, 4'd3, 4'd0, 4'd0, 4'd0, 4'b1111, S0, 2'd0));
        vecs.push_back(run(4'b1110, S3, 2'd0));
        vecs.push_back(mk(1'b0, 1'b1, 4'd8, 4'd0, 4'd0, 4'd0, 4'b1110, S3, 2'd0));
        // Load coinciding with terminal count: both take effect.
        vecs.push_back(mk(1'b0, 1'b1, 4'd8, 4'd6, 4'd0, 4'd0, 4'b1110, S8, 2'd1));
        vecs.push_back(run(4'b1111, S6, 2'd1));
        vecs.push_back(run(4'b1101, S6, 2'd1));

        @(negedge clock);
        for (int i = 0; i < vecs.size(); i++) begin
            reset   = vecs[i].rst;
            carrega = vecs[i].ld;
            digito1 = vecs[i].d1;
            digito2 = vecs[i].d2;
            digito3 = vecs[i].d3;
            digito4 = vecs[i].d4;
            @(posedge clock);
            #1;
            check(i, "anodos",    {3'b000, anodos},    {3'b000, vecs[i].exp_an});
            check(i, "segmentos", segmentos,           vecs[i].exp_seg);
            check(i, "indice",    {5'b00000, indice},  {5'b00000, vecs[i].exp_idx});
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
